e203_tcm_ram_pm: RTL
====================

// Module: e203_tcm_ram_pm
// PURPOSE
//  Parametrised single-port TCM SRAM model with byte-masked writes and a power-management FSM.
//  Successor to the fixed 8192x64 ITCM RAM: width, depth and wake latencies are generic.
//  Adds an access-ready flag, a read-data hold register and drop-error reporting.
//  Sits between the ITCM/DTCM controller and the SRAM macro boundary.
// PARAMETERS
//  DW       64                  data width in bits; must be a multiple of 8
//  MW       DW/8                write-mask width, one bit per byte lane
//  AW       13                  address width
//  DP       2**AW               depth in words
//  LS_WAKE  1                   cycles spent in WAKE after leaving light sleep
//  DS_WAKE  4                   cycles spent in WAKE after leaving deep sleep
//  SD_WAKE  16                  cycles spent in WAKE after leaving shutdown
// PORTS
//  clk      in   1    clock
//  rst_n    in   1    asynchronous active-low reset
//  sd       in   1    shutdown request (contents lost)
//  ds       in   1    deep-sleep request (contents retained, output off)
//  ls       in   1    light-sleep request (contents retained, output held)
//  cs       in   1    chip select / access request
//  we       in   1    1 = write, 0 = read
//  addr     in   AW   word address
//  wem      in   MW   byte write enable
//  din      in   DW   write data
//  dout     out  DW   registered read data
//  rdy      out  1    1 when pwr_st == ACT; an access is accepted only when this is 1
//  pwr_st   out  3    0 ACT, 1 LS, 2 DS, 3 SD, 4 WAKE
//  drop_err out  1    one-cycle pulse: cs was seen while rdy == 0
// BEHAVIOUR
//  Reset (async, rst_n=0):
//   - pwr_st=ACT, wake counter=0, dout=0, drop_err=0, rdy=1.
//   - Array is not cleared.
//  Requested mode:
//   - Priority sd > ds > ls. None asserted means the request is ACT.
//   - All inputs are sampled at posedge clk.
//  FSM:
//   - ACT: a sleep request moves to the requested sleep state at the next edge.
//   - Sleep state, deeper or different sleep requested: move directly to that sleep state.
//   - Sleep state, no request: go to WAKE, loading cnt = <X>_WAKE-1 for the sleep state just left.
//   - Sleep state, a latency of 0: go straight to ACT instead of WAKE.
//   - WAKE: cnt decrements each cycle. At cnt==0 the next state is ACT.
//     So WAKE lasts exactly <X>_WAKE cycles.
//   - WAKE with any sleep request: go to that sleep state; cnt is cleared.
//  Access (when cs & rdy):
//   - Write (we=1): byte lane i of mem[addr] takes din[8i+7:8i] iff wem[i]=1.
//   - Write does not change dout.
//   - Read (we=0): dout <= mem[addr] at the same edge, i.e. visible one cycle later.
//   - A read in the cycle after a write to the same address returns the new data.
//  dout hold:
//   - No read: dout keeps its last value, including in LS and WAKE.
//   - Entering DS or SD clears dout to 0.
//  Simultaneous access and sleep request in ACT:
//   - The access completes.
//   - The state changes at the same edge, so rdy=0 from the next cycle.
//  cs while rdy=0:
//   - Access is ignored; array and dout are unchanged.
//   - drop_err=1 for the following cycle.
//  SD exit: array contents are unspecified; consumers rewrite before reading.
//  addr >= DP: the access is ignored; no error is flagged.
//  Counter width is $clog2(max(LS_WAKE,DS_WAKE,SD_WAKE)+1).
// TESTING
//  1. Reset: rst_n 0 while in WAKE -> immediately pwr_st=0, rdy=1, dout=0, drop_err=0.
//  2. Byte mask:
//     - wr 0x0005 din=0x0123456789ABCDEF wem=0xFF.
//     - wr 0x0005 din=~0 wem=0x0F.
//     - rd 0x0005 -> next cycle dout=0x01234567FFFFFFFF.
//  3. Light sleep:
//     - ls=1 for 3 cycles -> pwr_st=1, rdy=0.
//     - Release -> pwr_st=4 for 1 cycle, then 0.
//     - Prior read value is held on dout throughout.
//  4. Drop: in DS, cs=1 we=1 addr=0x0005 din=0 -> drop_err pulses 1 cycle; after wake, rd 0x0005 returns 0x01234567FFFFFFFF.
//  5. Priority: ds=1 sd=1 together -> pwr_st=3, dout=0; release both -> WAKE for exactly 16 cycles, then rdy=1.
//  6. Re-sleep in WAKE: release ds, assert ls on the 2nd WAKE cycle -> pwr_st=1; release -> WAKE 1 cycle -> ACT.

Source files
------------

// File: rtl/e203_tcm_ram_pm.sv
// Parametrised single-port TCM SRAM model with byte-masked writes, a read-data
// hold register and a light-sleep / deep-sleep / shutdown power-management FSM.
module e203_tcm_ram_pm #(
  parameter int DW      = 64,
  parameter int MW      = DW / 8,
  parameter int AW      = 13,
  parameter int DP      = 2 ** AW,
  parameter int LS_WAKE = 1,
  parameter int DS_WAKE = 4,
  parameter int SD_WAKE = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          sd,
  input  logic          ds,
  input  logic          ls,
  input  logic          cs,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [MW-1:0] wem,
  input  logic [DW-1:0] din,
  output logic [DW-1:0] dout,
  output logic          rdy,
  output logic [2:0]    pwr_st,
  output logic          drop_err
);

  localparam int MAX_AB = (LS_WAKE > DS_WAKE) ? LS_WAKE : DS_WAKE;
  localparam int MAX_W  = (MAX_AB > SD_WAKE) ? MAX_AB : SD_WAKE;
  localparam int CW     = (MAX_W > 0) ? $clog2(MAX_W + 1) : 1;
  localparam logic [AW:0] DP_L = (AW + 1)'(DP);

  typedef enum logic [2:0] {
    ST_ACT  = 3'd0,
    ST_LS   = 3'd1,
    ST_DS   = 3'd2,
    ST_SD   = 3'd3,
    ST_WAKE = 3'd4
  } pwr_e;

  logic [DW-1:0] mem [DP];

  pwr_e          st_q, st_d, req;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [DW-1:0] dout_q, dout_d;
  logic          drop_q, drop_d;
  logic          rdy_w, in_range, wr_en, rd_en;
  int            lat;

  assign rdy_w    = (st_q == ST_ACT);
  assign in_range = ({1'b0, addr} < DP_L);
  assign wr_en    = cs & rdy_w & in_range & we;
  assign rd_en    = cs & rdy_w & in_range & ~we;

  always_comb begin
    req = ST_ACT;
    if (sd)      req = ST_SD;
    else if (ds) req = ST_DS;
    else if (ls) req = ST_LS;

    st_d  = st_q;
    cnt_d = cnt_q;
    lat   = 0;
    case (st_q)
      ST_ACT: st_d = req;
      ST_LS, ST_DS, ST_SD: begin
        if (req != ST_ACT) begin
          st_d = req;
        end else begin
          if (st_q == ST_LS)      lat = LS_WAKE;
          else if (st_q == ST_DS) lat = DS_WAKE;
          else                    lat = SD_WAKE;
          if (lat == 0) begin
            st_d = ST_ACT;
          end else begin
            st_d  = ST_WAKE;
            cnt_d = CW'(lat - 1);
          end
        end
      end
      ST_WAKE: begin
        if (req != ST_ACT) begin
          st_d  = req;
          cnt_d = '0;
        end else if (cnt_q == '0) begin
          st_d = ST_ACT;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: begin
        st_d  = ST_ACT;
        cnt_d = '0;
      end
    endcase

    // Output-off on DS/SD entry takes precedence over a read completing at that edge.
    dout_d = dout_q;
    if (rd_en) dout_d = mem[addr];
    if (st_d == ST_DS || st_d == ST_SD) dout_d = '0;

    drop_d = cs & ~rdy_w;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q   <= ST_ACT;
      cnt_q  <= '0;
      dout_q <= '0;
      drop_q <= 1'b0;
    end else begin
      st_q   <= st_d;
      cnt_q  <= cnt_d;
      dout_q <= dout_d;
      drop_q <= drop_d;
    end
  end

  // Array is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int i = 0; i < MW; i++) begin
        if (wem[i]) mem[addr][8*i +: 8] <= din[8*i +: 8];
      end
    end
  end

  assign dout     = dout_q;
  assign rdy      = rdy_w;
  assign pwr_st   = st_q;
  assign drop_err = drop_q;

endmodule
